// File: rtl/bound_flasher_gen_if.sv
// Control/config inputs and LED/status outputs of bound_flasher_gen, grouped
// so the sequencer drops in with a single bus port besides clk/reset.
interface bound_flasher_gen_if #(
    parameter int N_LED   = 16,
    parameter int N_PHASE = 6,
    parameter int CW      = $clog2(N_LED + 1),
    parameter int PW      = $clog2(N_PHASE)
) ();
    logic              flick;
    logic              hold;
    logic              loop_en;
    logic              cfg_we;
    logic [PW:0]       cfg_addr;
    logic [CW-1:0]     cfg_wdata;
    logic [N_LED-1:0]  led;
    logic [1:0]        state;
    logic [PW-1:0]     phase;
    logic [CW-1:0]     count;
    logic              done;

    modport master (
        output flick, hold, loop_en, cfg_we, cfg_addr, cfg_wdata,
        input  led, state, phase, count, done
    );

    modport slave (
        input  flick, hold, loop_en, cfg_we, cfg_addr, cfg_wdata,
        output led, state, phase, count, done
    );
endinterface

// File: rtl/bound_flasher_gen.sv
// Programmable bound flasher: thermometer LED bar sequenced through up/down
// phases with run-time bounds, kick-back on flick, loop mode and hold.
module bound_flasher_gen #(
    parameter int                    N_LED      = 16,
    parameter int                    N_PHASE    = 6,
    parameter int                    CW         = $clog2(N_LED + 1),
    parameter int                    PW         = $clog2(N_PHASE),
    parameter logic [N_PHASE*CW-1:0] BOUND_INIT = {5'd0, 5'd6, 5'd0, 5'd11, 5'd6, 5'd16},
    parameter int                    KICK0_INIT = 0,
    parameter int                    KICK1_INIT = 6
) (
    input logic                clk,
    input logic                reset,
    bound_flasher_gen_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_UP   = 2'b01,
        ST_DOWN = 2'b10
    } state_t;

    localparam logic [PW-1:0] LAST    = PW'(N_PHASE - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(N_LED);

    state_t          r_state;
    logic [PW-1:0]   r_phase;
    logic [CW-1:0]   r_count;
    logic            r_done;
    logic [CW-1:0]   r_bound [N_PHASE];
    logic [CW-1:0]   r_kick0;
    logic [CW-1:0]   r_kick1;

    logic [CW-1:0]   w_bound;
    logic [CW-1:0]   w_wdata;
    logic            w_step_up;
    logic            w_step_dn;
    logic            w_kick;
    logic [N_LED-1:0] w_led;

    assign w_bound   = r_bound[r_phase];
    assign w_wdata   = (bus.cfg_wdata > CNT_MAX) ? CNT_MAX : bus.cfg_wdata;
    assign w_step_up = (r_state == ST_UP)   && (r_count < w_bound);
    assign w_step_dn = (r_state == ST_DOWN) && (r_count > w_bound);
    assign w_kick    = (r_state == ST_DOWN) && (r_phase != LAST) && bus.flick &&
                       ((r_count == r_kick0) || (r_count == r_kick1));

    // Table writes ignore hold so the bar can be reprogrammed while frozen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < N_PHASE; i++)
                r_bound[i] <= BOUND_INIT[i*CW +: CW];
            r_kick0 <= CW'(KICK0_INIT);
            r_kick1 <= CW'(KICK1_INIT);
        end else if (bus.cfg_we) begin
            if (bus.cfg_addr < (PW+1)'(N_PHASE))
                r_bound[bus.cfg_addr[PW-1:0]] <= w_wdata;
            else if (bus.cfg_addr == (PW+1)'(N_PHASE))
                r_kick0 <= w_wdata;
            else if (bus.cfg_addr == (PW+1)'(N_PHASE + 1))
                r_kick1 <= w_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_phase <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
        end else if (bus.hold) begin
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_IDLE) begin
                r_count <= '0;
                if (bus.flick) begin
                    r_state <= ST_UP;
                    r_phase <= '0;
                    r_count <= CW'(1);
                end
            end else if (w_kick) begin
                r_state <= ST_UP;
                r_phase <= r_phase - PW'(1);
                r_count <= r_count + CW'(1);
            end else if (w_step_up) begin
                r_count <= r_count + CW'(1);
            end else if (w_step_dn) begin
                r_count <= r_count - CW'(1);
            end else if (r_phase == LAST) begin
                // Dwell at the final bound: wrap or finish, pulsing done.
                r_done  <= 1'b1;
                r_phase <= '0;
                if (bus.loop_en) begin
                    r_state <= ST_UP;
                end else begin
                    r_state <= ST_IDLE;
                    r_count <= '0;
                end
            end else begin
                r_phase <= r_phase + PW'(1);
                r_state <= r_phase[0] ? ST_UP : ST_DOWN;
            end
        end
    end

    always_comb begin
        w_led = '0;
        for (int unsigned i = 0; i < N_LED; i++)
            w_led[i] = (CW'(i) < r_count);
    end

    assign bus.led   = w_led;
    assign bus.state = r_state;
    assign bus.phase = r_phase;
    assign bus.count = r_count;
    assign bus.done  = r_done;
endmodule

// File: tb/tb_bound_flasher_gen.sv
// Self-checking bench for bound_flasher_gen: vector table, directed corner
// sequences and a randomized run against a phase/count reference model.
module tb_bound_flasher_gen;
    localparam int N_LED   = 16;
    localparam int N_PHASE = 6;
    localparam int CW      = $clog2(N_LED + 1);
    localparam int PW      = $clog2(N_PHASE);

    logic clk;
    logic reset;

    bound_flasher_gen_if #(.N_LED(N_LED), .N_PHASE(N_PHASE), .CW(CW), .PW(PW)) bus ();

    bound_flasher_gen #(.N_LED(N_LED), .N_PHASE(N_PHASE), .CW(CW), .PW(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int n;
        bit flick;
        bit hold;
        bit loop_en;
        int cnt;
        int ph;
        int st;
        bit dn;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: running flag, phase index, lit count.
    bit m_run;
    int m_phase;
    int m_count;
    bit m_done;
    int m_bound[N_PHASE];
    int m_kick[2];

    function automatic int thermo(input int c);
        logic [N_LED:0] t;
        t = (N_LED+1)'(1) << c;
        return int'(N_LED'(t - 1));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic exp_out(input string tag, input int c, input int p, input int s, input int d);
        chk({tag, ".count"}, int'(bus.count), c);
        chk({tag, ".phase"}, int'(bus.phase), p);
        chk({tag, ".state"}, int'(bus.state), s);
        chk({tag, ".done"},  int'(bus.done),  d);
        chk({tag, ".led"},   int'(bus.led),   thermo(c));
    endtask

    task automatic model_reset();
        m_run   = 1'b0;
        m_phase = 0;
        m_count = 0;
        m_done  = 1'b0;
        m_bound = '{16, 6, 11, 0, 6, 0};
        m_kick  = '{0, 6};
    endtask

    task automatic model_edge(input bit fl, input bit hd, input bit lp,
                              input bit we, input int addr, input int wdata);
        int  b;
        bit  up;
        m_done = 1'b0;
        if (!hd) begin
            if (!m_run) begin
                if (fl) begin
                    m_run = 1'b1; m_phase = 0; m_count = 1;
                end
            end else begin
                b  = m_bound[m_phase];
                up = (m_phase % 2 == 0);
                if (!up && m_phase != N_PHASE - 1 && fl &&
                    (m_count == m_kick[0] || m_count == m_kick[1])) begin
                    m_count++; m_phase--;
                end else if (up && m_count < b) begin
                    m_count++;
                end else if (!up && m_count > b) begin
                    m_count--;
                end else if (m_phase == N_PHASE - 1) begin
                    m_done  = 1'b1;
                    m_phase = 0;
                    if (!lp) begin
                        m_run = 1'b0; m_count = 0;
                    end
                end else begin
                    m_phase++;
                end
            end
        end
        if (we) begin
            int v;
            v = (wdata > N_LED) ? N_LED : wdata;
            if (addr < N_PHASE) m_bound[addr] = v;
            else if (addr == N_PHASE) m_kick[0] = v;
            else if (addr == N_PHASE + 1) m_kick[1] = v;
        end
    endtask

    task automatic model_check(input string tag);
        exp_out(tag, m_count, m_phase, !m_run ? 0 : ((m_phase % 2 == 0) ? 1 : 2), int'(m_done));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        bus.flick = 0; bus.hold = 0; bus.loop_en = 0;
        bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic flick_pulse();
        bus.flick = 1'b1;
        step(1);
        bus.flick = 1'b0;
    endtask

    task automatic cfg_write(input int addr, input int data);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = (PW+1)'(addr);
        bus.cfg_wdata = CW'(data);
        step(1);
        bus.cfg_we    = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        #1;
        do_reset();
        exp_out("reset", 0, 0, 0, 0);

        // Default run: flick at edge 1, checkpoints at spec edge numbers.
        vecs.push_back('{1,  1, 0, 0,  1, 0, 1, 0});
        vecs.push_back('{7,  0, 0, 0,  8, 0, 1, 0});
        vecs.push_back('{8,  0, 0, 0, 16, 0, 1, 0});
        vecs.push_back('{1,  0, 0, 0, 16, 1, 2, 0});
        vecs.push_back('{10, 0, 0, 0,  6, 1, 2, 0});
        vecs.push_back('{1,  0, 0, 0,  6, 2, 1, 0});
        vecs.push_back('{5,  0, 0, 0, 11, 2, 1, 0});
        vecs.push_back('{1,  0, 0, 0, 11, 3, 2, 0});
        vecs.push_back('{11, 0, 0, 0,  0, 3, 2, 0});
        vecs.push_back('{1,  0, 0, 0,  0, 4, 1, 0});
        vecs.push_back('{6,  0, 0, 0,  6, 4, 1, 0});
        vecs.push_back('{1,  0, 0, 0,  6, 5, 2, 0});
        vecs.push_back('{6,  0, 0, 0,  0, 5, 2, 0});
        vecs.push_back('{1,  0, 0, 0,  0, 0, 0, 1});
        vecs.push_back('{1,  0, 0, 0,  0, 0, 0, 0});
        vecs.push_back('{3,  0, 0, 0,  0, 0, 0, 0});
        for (int i = 0; i < vecs.size(); i++) begin
            bus.flick   = vecs[i].flick;
            bus.hold    = vecs[i].hold;
            bus.loop_en = vecs[i].loop_en;
            step(vecs[i].n);
            exp_out($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ph, vecs[i].st, int'(vecs[i].dn));
        end

        // Kick in phase 3, then flick at count 0 in the last phase is ignored.
        do_reset();
        flick_pulse();
        step(38);
        exp_out("kick3.pre", 6, 3, 2, 0);
        bus.flick = 1'b1;
        step(1);
        bus.flick = 1'b0;
        exp_out("kick3.hit", 7, 2, 1, 0);
        step(4);
        exp_out("kick3.peak", 11, 2, 1, 0);
        step(1);
        exp_out("kick3.dwell", 11, 3, 2, 0);
        step(25);
        exp_out("kick3.last0", 0, 5, 2, 0);
        bus.flick = 1'b1;
        step(1);
        bus.flick = 1'b0;
        exp_out("kick3.ignored", 0, 0, 0, 1);
        step(1);
        exp_out("kick3.idle", 0, 0, 0, 0);

        // Kick while dwelling at the phase 1 bound.
        do_reset();
        flick_pulse();
        step(26);
        exp_out("kickdw.pre", 6, 1, 2, 0);
        bus.flick = 1'b1;
        step(1);
        bus.flick = 1'b0;
        exp_out("kickdw.hit", 7, 0, 1, 0);
        step(9);
        exp_out("kickdw.peak", 16, 0, 1, 0);

        // Loop mode wraps to phase 0 without visiting IDLE.
        do_reset();
        bus.loop_en = 1'b1;
        flick_pulse();
        step(58);
        exp_out("loop.last", 0, 5, 2, 0);
        step(1);
        exp_out("loop.wrap", 0, 0, 1, 1);
        step(1);
        exp_out("loop.next", 1, 0, 1, 0);
        bus.loop_en = 1'b0;

        // Hold freezes sequencing and ignores flick.
        do_reset();
        flick_pulse();
        step(4);
        exp_out("hold.pre", 5, 0, 1, 0);
        bus.hold = 1'b1; bus.flick = 1'b1;
        step(5);
        exp_out("hold.frozen", 5, 0, 1, 0);
        bus.hold = 1'b0; bus.flick = 1'b0;
        step(1);
        exp_out("hold.resume", 6, 0, 1, 0);

        // Oversized bound clamps to N_LED.
        do_reset();
        cfg_write(0, 20);
        flick_pulse();
        step(15);
        exp_out("clamp.peak", 16, 0, 1, 0);
        step(1);
        exp_out("clamp.dwell", 16, 1, 2, 0);

        // Lowering the current bound below count forces a dwell next decision.
        do_reset();
        flick_pulse();
        step(7);
        exp_out("lower.pre", 8, 0, 1, 0);
        cfg_write(0, 4);
        exp_out("lower.wr", 9, 0, 1, 0);
        step(1);
        exp_out("lower.dwell", 9, 1, 2, 0);

        // Async reset mid-DOWN clears outputs at once and restores the table.
        do_reset();
        cfg_write(0, 3);
        flick_pulse();
        step(3);
        exp_out("arst.pre", 3, 1, 2, 0);
        reset = 1'b0;
        #1;
        exp_out("arst.now", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        flick_pulse();
        step(15);
        exp_out("arst.peak", 16, 0, 1, 0);
        step(1);
        exp_out("arst.dwell", 16, 1, 2, 0);

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b0;
                #1;
                model_reset();
                model_check("rnd.arst");
                @(posedge clk);
                #1;
                reset = 1'b1;
            end
            bus.flick     = ($urandom_range(0, 3) == 0);
            bus.hold      = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 99) == 0) bus.loop_en = ~bus.loop_en;
            bus.cfg_we    = ($urandom_range(0, 23) == 0);
            bus.cfg_addr  = (PW+1)'($urandom_range(0, 15));
            bus.cfg_wdata = CW'($urandom_range(0, 31));
            model_edge(bus.flick, bus.hold, bus.loop_en, bus.cfg_we,
                       int'(bus.cfg_addr), int'(bus.cfg_wdata));
            @(posedge clk);
            #1;
            model_check($sformatf("rnd%0d", cyc));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/bound_flasher_gen.md
# bound_flasher_gen

Parametrised, programmable successor of the bound flasher. It drives an N_LED-wide thermometer LED bar through a sequence of up/down phases whose turn-around bounds sit in a run-time-writable table, and restarts a previous up phase on a "flick" at programmable kick points. Optional loop mode, hold/freeze, and a completion pulse are included. It sits between the board's button synchroniser (flick/hold are already synchronous to clk) and the LED pins.

## Interface
- N_LED, 16: LED bar width; count range 0..N_LED.
- N_PHASE, 6: number of phases (even, ≥2). Even phases run UP, odd phases run DOWN.
- CW, $clog2(N_LED+1): count/bound width.
- PW, $clog2(N_PHASE): phase index width.
- BOUND_INIT, {5'd0,5'd6,5'd0,5'd11,5'd6,5'd16}: reset table. Entry i = BOUND_INIT[i*CW +: CW]. Default is 16,6,11,0,6,0.
- KICK0_INIT, 0 / KICK1_INIT, 6: reset kick points.

Ports:
- clk  in  1  clock (rising edge).
- reset  in  1  asynchronous, active-low reset.
- flick  in  1  start from IDLE / kick-back request, sampled at clk.
- hold  in  1  freeze all sequencing while 1.
- loop_en  in  1  1: wrap after last phase instead of returning to IDLE.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  PW+1  0..N_PHASE-1 = bound[i]; N_PHASE = kick0; N_PHASE+1 = kick1; others ignored.
- cfg_wdata  in  CW  write data; values > N_LED are stored as N_LED.
- led  out  N_LED  thermometer: (1<<count)-1.
- state  out  2  00 IDLE, 01 UP, 10 DOWN.
- phase  out  PW  current phase index.
- count  out  CW  number of LEDs lit.
- done  out  1  one-cycle pulse on sequence completion.

## Operation
- Reset (reset=0, async): state IDLE, phase 0, count 0, led 0, done 0, table to BOUND_INIT/KICK*_INIT.
- Priority per edge: reset > hold > flick action > normal step. Config writes are independent of hold and take effect the next cycle.
- IDLE: count held at 0. If flick=1, go to UP, phase 0, count 1. Otherwise stay.
- UP (phase even, b = bound[phase]):
  - If count < b: count+1.
  - Else (count ≥ b, including a bound lowered mid-run): dwell. Count holds and the phase advances to the next (DOWN).
- DOWN (phase odd):
  - If count > b: count−1.
  - Else: dwell, phase advances (UP).
- Kick-back: in DOWN, with phase ≠ N_PHASE−1, count == kick0 or kick1, and flick=1: count+1, phase−1, state UP. This overrides that cycle's step or dwell. Flick is ignored in UP and in the last phase.
- Phase advance past N_PHASE−1:
  - loop_en=0: IDLE, phase 0, count 0.
  - loop_en=1: UP, phase 0, count unchanged.
  - Either way, done=1 for that one cycle.
- hold=1: state, phase, count and done freeze (done forced 0). Flick is ignored.
- done is 0 at all other times.

## Timing
- All outputs change only at a rising clk edge or at reset assertion. led is a pure decode of registered count, so there is no extra latency.
- Flick takes effect on the edge it is sampled at; there is no asynchronous flick path.
- Each turn-around costs exactly one dwell cycle at the bound.
- The new table value is used starting the cycle after the cfg_we edge. A write to the current phase's bound applies immediately on the next step decision.
- Reset deasserted mid-sequence: the block restarts in IDLE and needs a fresh flick.

## Test plan
- Default run: reset, then flick=1 for one edge (edge 1), loop_en=0.
  - Required: count=1 after edge 1, 16 at edge 16, dwell at edge 17.
  - Then 6 at edge 27; 11 at edge 33; 0 at edge 45; 6 at edge 52; 0 at edge 59.
  - Edge 60: state IDLE, done=1 for one cycle only. led is 16'h00FF when count=8.
- Kick in phase 3: flick at the edge after count reaches 6 going down (edge 40) -> count 7, phase 2, UP; climbs to 11 again. Flick held at count 0 in phase 5 -> ignored, returns to IDLE.
- Kick during dwell: flick at edge 28 (phase 1, count 6) -> count 7, phase 0, climbs to 16.
- Loop: loop_en=1 -> after phase 5 dwell, done pulse, phase 0, UP, count 0→1 on the next edge; no IDLE visit.
- Hold/config: hold=1 for 5 cycles mid-UP -> count frozen, flick ignored. Write bound[0]=20 with N_LED=16 -> reads as a 16 peak. Write bound[0]=4 while count=9 in phase 0 -> next edge dwell, phase 1.
- Async reset mid-DOWN (reset low between edges) -> outputs 0/IDLE immediately; table back to defaults.
